// File: rtl/tlu_arb_pkg.sv
// Shared types and constants for the TLU readout arbiter: state encoding,
// bus register map, default version and the stall-abort limit.
package tlu_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int ADDR_RESET   = 0;
    localparam int ADDR_MASK    = 1;
    localparam int ADDR_STATUS  = 2;
    localparam int ADDR_PKT_LO  = 3;
    localparam int ADDR_PKT_HI  = 4;
    localparam int ADDR_TIMEOUT = 5;

    localparam int VERSION       = 1;
    localparam int TIMEOUT_LIMIT = 255;

endpackage

// File: rtl/tlu_rr_picker.sv
// Combinational round-robin picker: first candidate after 'last', wrapping,
// with 'last' itself checked last.
module tlu_rr_picker #(
    parameter int N_SRC = 2,
    parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] candidates,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] pos;

    // Scan from the farthest offset down so the nearest candidate is written last and wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            pos = IDX_W'((int'(last) + k) % N_SRC);
            if (candidates[pos]) begin
                valid = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/tlu_readout_arbiter.sv
// Packet-aware round-robin arbiter feeding the host readout path from N_SRC FWFT sources.
// Define ARB_TIMEOUT_EN to abort packets whose source stalls for too long.
module tlu_readout_arbiter #(
    parameter int ABUSWIDTH = 16,
    parameter int N_SRC     = 2,
    parameter int PKT_WORDS = 8,
    parameter int VERSION   = tlu_arb_pkg::VERSION
) (
    input  logic                   BUS_CLK,
    input  logic                   RST,
    input  logic [N_SRC-1:0]       SRC_EMPTY,
    input  logic [16*N_SRC-1:0]    SRC_DATA,
    output logic [N_SRC-1:0]       SRC_READ,
    input  logic                   OUT_READ,
    output logic                   OUT_EMPTY,
    output logic [15:0]            OUT_DATA,
    input  logic [ABUSWIDTH-1:0]   BUS_ADD,
    input  logic [7:0]             BUS_DATA_IN,
    output logic [7:0]             BUS_DATA_OUT,
    input  logic                   BUS_WR,
    input  logic                   BUS_RD
);

    import tlu_arb_pkg::*;

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    arb_state_t       state, next_state;
    logic [IDX_W-1:0] grant, last, pick;
    logic             pick_valid;
    logic [7:0]       word_cnt;
    logic [N_SRC-1:0] enable;
    logic [15:0]      packet_cnt;
    logic [7:0]       timeout_rd;
    logic [7:0]       rd_data;
    logic             lock, pop, end_pkt, abort, rst_int;
    logic             unused_bus_bits;

    assign unused_bus_bits = ^BUS_DATA_IN;

    // A write to register 0 resets everything on the same edge as RST would.
    assign rst_int = RST | (BUS_WR && BUS_ADD == ABUSWIDTH'(ADDR_RESET));

    assign lock      = (state == LOCK);
    assign OUT_EMPTY = lock ? SRC_EMPTY[grant] : 1'b1;
    assign OUT_DATA  = lock ? SRC_DATA[{grant, 4'b0000} +: 16] : 16'h0000;
    assign pop       = lock & OUT_READ & ~SRC_EMPTY[grant];
    assign SRC_READ  = pop ? (N_SRC'(1) << grant) : '0;
    assign end_pkt   = pop && (word_cnt == 8'(PKT_WORDS - 1));

    tlu_rr_picker #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) picker (
        .candidates (enable & ~SRC_EMPTY),
        .last       (last),
        .valid      (pick_valid),
        .index      (pick)
    );

    always_ff @(posedge BUS_CLK) begin
        if (rst_int) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_valid) next_state = LOCK;
            LOCK:    if (end_pkt || abort) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (rst_int) begin
            grant      <= '0;
            last       <= IDX_W'(N_SRC - 1);
            word_cnt   <= 8'd0;
            packet_cnt <= 16'd0;
        end else begin
            if (state == IDLE && pick_valid) begin
                grant    <= pick;
                word_cnt <= 8'd0;
            end else if (pop) begin
                word_cnt <= word_cnt + 8'd1;
            end
            if (end_pkt || abort) last <= grant;
            if (end_pkt && packet_cnt != 16'hFFFF) packet_cnt <= packet_cnt + 16'd1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] stall_cnt;
    logic [7:0] timeout_cnt;

    assign abort      = lock && SRC_EMPTY[grant] && (stall_cnt == 8'(TIMEOUT_LIMIT));
    assign timeout_rd = timeout_cnt;

    // Stall count only advances while the granted source starves an open packet.
    always_ff @(posedge BUS_CLK) begin
        if (rst_int) begin
            stall_cnt   <= 8'd0;
            timeout_cnt <= 8'd0;
        end else begin
            if (!lock || pop || abort) stall_cnt <= 8'd0;
            else if (SRC_EMPTY[grant]) stall_cnt <= stall_cnt + 8'd1;
            if (abort && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
        end
    end
`else
    assign abort      = 1'b0;
    assign timeout_rd = 8'h00;
`endif

    always_comb begin
        rd_data = 8'h00;
        if (BUS_ADD == ABUSWIDTH'(ADDR_RESET))        rd_data = 8'(VERSION);
        else if (BUS_ADD == ABUSWIDTH'(ADDR_MASK))    rd_data = 8'(enable);
        else if (BUS_ADD == ABUSWIDTH'(ADDR_STATUS))  rd_data = {lock, 4'b0000, 3'(grant)};
        else if (BUS_ADD == ABUSWIDTH'(ADDR_PKT_LO))  rd_data = packet_cnt[7:0];
        else if (BUS_ADD == ABUSWIDTH'(ADDR_PKT_HI))  rd_data = packet_cnt[15:8];
        else if (BUS_ADD == ABUSWIDTH'(ADDR_TIMEOUT)) rd_data = timeout_rd;
    end

    always_ff @(posedge BUS_CLK) begin
        if (rst_int) begin
            enable       <= '1;
            BUS_DATA_OUT <= 8'h00;
        end else begin
            if (BUS_WR && BUS_ADD == ABUSWIDTH'(ADDR_MASK)) enable <= BUS_DATA_IN[N_SRC-1:0];
            if (BUS_RD) BUS_DATA_OUT <= rd_data;
        end
    end

endmodule

// File: tb/tb_tlu_readout_arbiter.sv
// Self-checking bench for tlu_readout_arbiter: queue-backed sources, a packet-level
// arbitration model checked every cycle, and literal pins on order, timing and registers.
module tb_tlu_readout_arbiter;

    localparam int PKT = 8;

    logic        BUS_CLK = 1'b0;
    logic        RST;
    logic [1:0]  SRC_EMPTY;
    logic [31:0] SRC_DATA;
    logic [1:0]  SRC_READ;
    logic        OUT_READ;
    logic        OUT_EMPTY;
    logic [15:0] OUT_DATA;
    logic [15:0] BUS_ADD;
    logic [7:0]  BUS_DATA_IN;
    logic [7:0]  BUS_DATA_OUT;
    logic        BUS_WR;
    logic        BUS_RD;

    always #5 BUS_CLK = ~BUS_CLK;

    tlu_readout_arbiter #(
        .ABUSWIDTH (16),
        .N_SRC     (2),
        .PKT_WORDS (PKT),
        .VERSION   (1)
    ) dut (
        .BUS_CLK      (BUS_CLK),
        .RST          (RST),
        .SRC_EMPTY    (SRC_EMPTY),
        .SRC_DATA     (SRC_DATA),
        .SRC_READ     (SRC_READ),
        .OUT_READ     (OUT_READ),
        .OUT_EMPTY    (OUT_EMPTY),
        .OUT_DATA     (OUT_DATA),
        .BUS_ADD      (BUS_ADD),
        .BUS_DATA_IN  (BUS_DATA_IN),
        .BUS_DATA_OUT (BUS_DATA_OUT),
        .BUS_WR       (BUS_WR),
        .BUS_RD       (BUS_RD)
    );

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int stall_at[2];
    int stall_len[2];
    int stall_left[2];
    int popped[2];

    // Model: who owns the output, how far into the packet, who went last.
    int         m_owner, m_last, m_cnt, m_pkts, m_tmo, m_stall;
    logic [1:0] m_mask;

    logic [15:0] pop_word[$];
    int          pop_cyc[$];
    int          cyc;
    int          n_vec;
    int          n_err;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] front(input int s);
        if (s == 0) return (q0.size() > 0) ? q0[0] : 16'h0000;
        return (q1.size() > 0) ? q1[0] : 16'h0000;
    endfunction

    task automatic applyStimulus();
        SRC_EMPTY[0] = (q0.size() == 0) || (stall_left[0] > 0);
        SRC_EMPTY[1] = (q1.size() == 0) || (stall_left[1] > 0);
        SRC_DATA     = {front(1), front(0)};
    endtask

    task automatic checkOutput(input logic exp_empty, input logic [15:0] exp_data, input logic [1:0] exp_read);
        checkValue("out_empty", 32'(OUT_EMPTY), 32'(exp_empty));
        checkValue("out_data",  32'(OUT_DATA),  32'(exp_data));
        checkValue("src_read",  32'(SRC_READ),  32'(exp_read));
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_cnt   = 0;
        m_pkts  = 0;
        m_tmo   = 0;
        m_stall = 0;
        m_mask  = 2'b11;
    endtask

    task automatic step(input bit wr, input bit rd, input logic [15:0] addr, input logic [7:0] din);
        logic       exp_empty;
        logic [15:0] exp_data;
        logic [1:0] exp_read;
        logic [1:0] read_s;
        bit         found;
        BUS_WR      = wr;
        BUS_RD      = rd;
        BUS_ADD     = addr;
        BUS_DATA_IN = din;
        applyStimulus();
        #2;
        if (m_owner < 0) begin
            exp_empty = 1'b1;
            exp_data  = 16'h0000;
            exp_read  = 2'b00;
        end else begin
            exp_empty = SRC_EMPTY[m_owner];
            exp_data  = front(m_owner);
            exp_read  = (OUT_READ && !exp_empty) ? ((m_owner == 0) ? 2'b01 : 2'b10) : 2'b00;
        end
        checkOutput(exp_empty, exp_data, exp_read);
        read_s = SRC_READ;
        if (exp_read != 2'b00) begin
            pop_word.push_back(exp_data);
            pop_cyc.push_back(cyc);
        end
        if (wr && addr == 16'd0) begin
            model_reset();
        end else begin
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k <= 2; k++) begin
                    int c;
                    c = (m_last + k) % 2;
                    if (!found && m_mask[c] && !SRC_EMPTY[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_cnt   = 0;
                        m_stall = 0;
                    end
                end
            end else if (exp_read != 2'b00) begin
                m_cnt++;
                m_stall = 0;
                if (m_cnt == PKT) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    if (m_pkts < 65535) m_pkts++;
                end
            end
`ifdef ARB_TIMEOUT_EN
            else if (exp_empty) begin
                if (m_stall == 255) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_stall = 0;
                    if (m_tmo < 255) m_tmo++;
                end else begin
                    m_stall++;
                end
            end
`endif
            if (wr && addr == 16'd1) m_mask = din[1:0];
        end
        @(posedge BUS_CLK);
        for (int i = 0; i < 2; i++) if (stall_left[i] > 0) stall_left[i]--;
        if (read_s[0] && q0.size() > 0) begin void'(q0.pop_front()); popped[0]++; end
        if (read_s[1] && q1.size() > 0) begin void'(q1.pop_front()); popped[1]++; end
        for (int i = 0; i < 2; i++) begin
            if (stall_at[i] >= 0 && popped[i] == stall_at[i]) begin
                stall_left[i] = stall_len[i];
                stall_at[i]   = -1;
            end
        end
        cyc++;
        #1;
        BUS_WR = 1'b0;
        BUS_RD = 1'b0;
    endtask

    task automatic read_reg(input logic [15:0] addr, input logic [7:0] exp, input string name);
        step(1'b0, 1'b1, addr, 8'h00);
        checkValue(name, 32'(BUS_DATA_OUT), 32'(exp));
    endtask

    task automatic write_reg(input logic [15:0] addr, input logic [7:0] data);
        step(1'b1, 1'b0, addr, data);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic drain(input int maxc, input string name);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_owner >= 0) && n < maxc) begin
            idle_step();
            n++;
        end
        checkValue(name, (n < maxc) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic load(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            if (s == 0) q0.push_back(16'h1000 + 16'(k));
            else        q1.push_back(16'h2000 + 16'(k));
        end
    endtask

    task automatic clear_logs();
        pop_word.delete();
        pop_cyc.delete();
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        int n;
        int idx;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        for (int i = 0; i < 2; i++) begin
            stall_at[i]   = -1;
            stall_len[i]  = 0;
            stall_left[i] = 0;
            popped[i]     = 0;
        end
        RST = 1'b1; OUT_READ = 1'b0; BUS_WR = 1'b0; BUS_RD = 1'b0;
        BUS_ADD = 16'h0; BUS_DATA_IN = 8'h0; SRC_EMPTY = 2'b11; SRC_DATA = 32'h0;
        model_reset();
        repeat (3) @(posedge BUS_CLK);
        #1;
        RST = 1'b0;

        $display("[TB] reset values");
        checkValue("rst_bus_out", 32'(BUS_DATA_OUT), 32'h00);
        checkValue("rst_out_empty", 32'(OUT_EMPTY), 32'h1);
        checkValue("rst_src_read", 32'(SRC_READ), 32'h0);
        read_reg(16'd0, 8'h01, "version");
        read_reg(16'd1, 8'h03, "mask_rst");
        read_reg(16'd2, 8'h00, "status_rst");
        read_reg(16'd3, 8'h00, "pkt_lo_rst");
        read_reg(16'd5, 8'h00, "timeout_rst");

        $display("[TB] two sources, two packets each");
        clear_logs();
        load(0, 16);
        load(1, 16);
        OUT_READ = 1'b1;
        start = cyc;
        drain(200, "t1_drain");
        checkValue("t1_words", 32'(pop_word.size()), 32'd32);
        checkValue("t1_latency", 32'(pop_cyc[0] - start), 32'd1);
        checkValue("t1_w0", 32'(pop_word[0]), 32'h1000);
        checkValue("t1_w8", 32'(pop_word[8]), 32'h2000);
        checkValue("t1_w16", 32'(pop_word[16]), 32'h1008);
        checkValue("t1_w24", 32'(pop_word[24]), 32'h2008);
        checkValue("t1_w31", 32'(pop_word[31]), 32'h200F);
        checkValue("t1_gap1", 32'(pop_cyc[8] - pop_cyc[7]), 32'd2);
        checkValue("t1_gap3", 32'(pop_cyc[24] - pop_cyc[23]), 32'd2);
        checkValue("t1_span", 32'(pop_cyc[31] - pop_cyc[0]), 32'd34);
        checkValue("t1_model_pkts", 32'(m_pkts), 32'd4);
        read_reg(16'd3, 8'd4, "t1_pkt_lo");
        read_reg(16'd4, 8'd0, "t1_pkt_hi");

        $display("[TB] masked source");
        write_reg(16'd1, 8'h01);
        clear_logs();
        load(1, 8);
        repeat (5) idle_step();
        checkValue("t2_no_pop", 32'(q1.size()), 32'd8);
        OUT_READ = 1'b0;
        write_reg(16'd1, 8'h03);
        idle_step();
        read_reg(16'd2, 8'h81, "t2_status");
        OUT_READ = 1'b1;
        drain(100, "t2_drain");
        checkValue("t2_first", 32'(pop_word[0]), 32'h2000);

        $display("[TB] mid-packet source stall");
        clear_logs();
        load(0, 8);
        load(1, 8);
        stall_at[0]  = popped[0] + 4;
        stall_len[0] = 20;
        drain(200, "t3_drain");
        checkValue("t3_w4", 32'(pop_word[4]), 32'h1004);
        checkValue("t3_stall_gap", 32'(pop_cyc[4] - pop_cyc[3]), 32'd21);
        checkValue("t3_w7", 32'(pop_word[7]), 32'h1007);
        checkValue("t3_w8", 32'(pop_word[8]), 32'h2000);

        $display("[TB] OUT_READ while idle");
        write_reg(16'd1, 8'h00);
        clear_logs();
        load(0, 8);
        for (int i = 0; i < 6; i++) begin
            OUT_READ = (i % 2 == 0);
            idle_step();
        end
        checkValue("t6_no_pop", 32'(q0.size()), 32'd8);
        read_reg(16'd2, 8'h01, "t6_status_idle");
        OUT_READ = 1'b1;
        write_reg(16'd1, 8'h03);
        drain(100, "t6_drain");
        checkValue("t6_words", 32'(pop_word.size()), 32'd8);
        read_reg(16'd3, 8'd8, "t6_pkt_cnt");

        $display("[TB] soft reset mid-packet");
        write_reg(16'd1, 8'h01);
        clear_logs();
        load(0, 14);
        load(1, 8);
        start = popped[0];
        n = 0;
        while (popped[0] - start < 5 && n < 50) begin
            idle_step();
            n++;
        end
        checkValue("t5_reach_word5", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        write_reg(16'd0, 8'h00);
        idx = pop_word.size();
        checkValue("t5_abandon_at", 32'(idx), 32'd6);
        read_reg(16'd2, 8'h00, "t5_status");
        read_reg(16'd1, 8'h03, "t5_mask");
        read_reg(16'd3, 8'h00, "t5_pkt_cnt");
        read_reg(16'd0, 8'h01, "t5_version");
        drain(200, "t5_drain");
        checkValue("t5_resume", 32'(pop_word[idx]), 32'h1006);
        checkValue("t5_next_src1", 32'(pop_word[idx + 8]), 32'h2000);

`ifdef ARB_TIMEOUT_EN
        $display("[TB] stall timeout");
        clear_logs();
        load(0, 8);
        load(1, 8);
        stall_at[0]  = popped[0] + 3;
        stall_len[0] = 300;
        n = 0;
        while (pop_word.size() < 4 && n < 400) begin
            idle_step();
            n++;
        end
        checkValue("t4_reach_src1", (n < 400) ? 32'd1 : 32'd0, 32'd1);
        checkValue("t4_after_abort", 32'(pop_word[3]), 32'h2000);
        read_reg(16'd5, 8'h01, "t4_timeout_1");
        drain(1500, "t4_drain");
        read_reg(16'd5, 8'h02, "t4_timeout_2");
`else
        read_reg(16'd5, 8'h00, "t4_timeout_absent");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
